// File: rtl/rtc_pkg.sv
// Shared types, BCD range limits and load validation helper for the RTC time-of-day core.
package rtc_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX  = 8'h59;
    localparam bcd2_t MIN_MAX  = 8'h59;
    localparam bcd2_t HR24_MAX = 8'h23;
    localparam bcd2_t HR12_MAX = 8'h12;
    localparam bcd2_t HR12_MIN = 8'h01;

    // With both nibbles <= 9, a plain binary compare orders BCD values correctly.
    function automatic logic bcd2_valid(bcd2_t v, bcd2_t max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/rtc_bcd_mod60.sv
// Two-digit BCD 00..59 counter with synchronous load; carry is combinational on 59 -> 00.
module rtc_bcd_mod60
    import rtc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_inc,
    input  logic  i_ld,
    input  bcd2_t i_ld_val,
    output bcd2_t o_q,
    output logic  o_carry
);

    bcd2_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_ld_val;
        end else if (i_inc) begin
            if (r_q[3:0] == 4'd9) begin
                r_q[3:0] <= 4'd0;
                r_q[7:4] <= (r_q[7:4] == 4'd5) ? 4'd0 : r_q[7:4] + 4'd1;
            end else begin
                r_q[3:0] <= r_q[3:0] + 4'd1;
            end
        end
    end

    assign o_q     = r_q;
    assign o_carry = i_inc && (r_q == SEC_MAX);

endmodule

// File: rtl/rtc_time_counter.sv
// RTC time-of-day core: 1 Hz prescaler plus BCD hh:mm:ss with range-checked host load.
// Define RTC_12H_EN for 12-hour mode with a PM flag; default build is 24-hour.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    output logic [3:0] hh_t,
    output logic [3:0] hh_u,
    output logic [3:0] mm_t,
    output logic [3:0] mm_u,
    output logic [3:0] ss_t,
    output logic [3:0] ss_u,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam int unsigned      PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] r_pre;
    bcd2_t            r_hh;
    bcd2_t            w_ss;
    bcd2_t            w_mm;
    bcd2_t            w_hh_next;
    logic             r_sec;
    logic             r_day;
    logic             r_err;
    logic             w_tick;
    logic             w_load_ok;
    logic             w_ld_acc;
    logic             w_adv;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic             w_day;
    logic             w_pm_next;

    assign w_tick = en && (r_pre == PRE_LAST);

`ifdef RTC_12H_EN
    logic r_pm;
    assign w_load_ok = bcd2_valid(load_hh, HR12_MAX) && (load_hh >= HR12_MIN) &&
                       bcd2_valid(load_mm, MIN_MAX) && bcd2_valid(load_ss, SEC_MAX);
`else
    logic w_unused_pm;
    logic r_pm;
    assign w_unused_pm = load_pm;
    assign r_pm        = 1'b0;
    assign w_load_ok   = bcd2_valid(load_hh, HR24_MAX) &&
                         bcd2_valid(load_mm, MIN_MAX) && bcd2_valid(load_ss, SEC_MAX);
`endif

    // An accepted load wins over a coincident tick; a rejected load leaves the count alone.
    assign w_ld_acc = load && w_load_ok;
    assign w_adv    = w_tick && !w_ld_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_ld_acc || w_tick) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    rtc_bcd_mod60 u_sec (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_adv),
        .i_ld     (w_ld_acc),
        .i_ld_val (load_ss),
        .o_q      (w_ss),
        .o_carry  (w_sec_carry)
    );

    rtc_bcd_mod60 u_min (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_sec_carry),
        .i_ld     (w_ld_acc),
        .i_ld_val (load_mm),
        .o_q      (w_mm),
        .o_carry  (w_min_carry)
    );

    always_comb begin
        w_hh_next = r_hh;
        w_pm_next = r_pm;
        w_day     = 1'b0;
`ifdef RTC_12H_EN
        if (r_hh == HR12_MAX) begin
            w_hh_next = HR12_MIN;
        end else if (r_hh == 8'h11) begin
            w_hh_next = HR12_MAX;
            w_pm_next = ~r_pm;
            w_day     = r_pm;
        end else if (r_hh[3:0] == 4'd9) begin
            w_hh_next = {r_hh[7:4] + 4'd1, 4'd0};
        end else begin
            w_hh_next = r_hh + 8'd1;
        end
`else
        if (r_hh == HR24_MAX) begin
            w_hh_next = '0;
            w_day     = 1'b1;
        end else if (r_hh[3:0] == 4'd9) begin
            w_hh_next = {r_hh[7:4] + 4'd1, 4'd0};
        end else begin
            w_hh_next = r_hh + 8'd1;
        end
`endif
    end

`ifdef RTC_12H_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hh <= HR12_MAX;
            r_pm <= 1'b0;
        end else if (w_ld_acc) begin
            r_hh <= load_hh;
            r_pm <= load_pm;
        end else if (w_min_carry) begin
            r_hh <= w_hh_next;
            r_pm <= w_pm_next;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hh <= '0;
        end else if (w_ld_acc) begin
            r_hh <= load_hh;
        end else if (w_min_carry) begin
            r_hh <= w_hh_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec <= 1'b0;
            r_day <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_sec <= w_adv;
            r_day <= w_min_carry && w_day;
            r_err <= load && !w_load_ok;
        end
    end

    assign hh_t      = r_hh[7:4];
    assign hh_u      = r_hh[3:0];
    assign mm_t      = w_mm[7:4];
    assign mm_u      = w_mm[3:0];
    assign ss_t      = w_ss[7:4];
    assign ss_u      = w_ss[3:0];
    assign pm        = r_pm;
    assign sec_pulse = r_sec;
    assign day_pulse = r_day;
    assign load_err  = r_err;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed scoreboard bench for rtc_time_counter with CLK_HZ=4.
module tb_rtc_time_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       load_pm;
    logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;
    logic       load_err;
    logic [23:0] now;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [23:0] t;
        logic        pm;
        logic        day;
    } exp_t;

    exp_t sb[$];

    rtc_time_counter #(.CLK_HZ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_hh   (load_hh),
        .load_mm   (load_mm),
        .load_ss   (load_ss),
        .load_pm   (load_pm),
        .hh_t      (hh_t),
        .hh_u      (hh_u),
        .mm_t      (mm_t),
        .mm_u      (mm_u),
        .ss_t      (ss_t),
        .ss_u      (ss_u),
        .pm        (pm),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    assign now = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic p);
        load    = 1'b1;
        load_hh = h;
        load_mm = m;
        load_ss = s;
        load_pm = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic push(input logic [23:0] t, input logic p, input logic d);
        exp_t e;
        e.t   = t;
        e.pm  = p;
        e.day = d;
        sb.push_back(e);
    endtask

    // Waits (bounded) for sec_pulse, checks latency and the queued expectation,
    // then checks both strobes drop after one cycle.
    task automatic wait_pulse(input string tag, input int expn);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sec_pulse !== 1'b1 && n < 40);
        chk({tag, "_lat"}, n, expn);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_time"}, now, e.t);
            chk({tag, "_pm"}, pm, e.pm);
            chk({tag, "_day"}, day_pulse, e.day);
        end
        @(negedge clk);
        chk({tag, "_sec_off"}, sec_pulse, 0);
        chk({tag, "_day_off"}, day_pulse, 0);
    endtask

    initial begin
        int pc;
        rst     = 1'b1;
        en      = 1'b1;
        load    = 1'b0;
        load_hh = '0;
        load_mm = '0;
        load_ss = '0;
        load_pm = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sec", sec_pulse, 0);
        chk("rst_day", day_pulse, 0);
        chk("rst_err", load_err, 0);
        chk("rst_pm", pm, 0);
`ifdef RTC_12H_EN
        chk("rst_time", now, 24'h120000);
        rst = 1'b0;
        push(24'h120001, 1'b0, 1'b0);
        wait_pulse("first", 4);

        do_load(8'h11, 8'h59, 8'h59, 1'b0);
        chk("ld11_err", load_err, 0);
        push(24'h120000, 1'b1, 1'b0);
        wait_pulse("am_to_pm", 4);

        do_load(8'h11, 8'h59, 8'h59, 1'b1);
        push(24'h120000, 1'b0, 1'b1);
        wait_pulse("pm_to_am", 4);

        do_load(8'h12, 8'h59, 8'h59, 1'b0);
        push(24'h010000, 1'b0, 1'b0);
        wait_pulse("h12_to_01", 4);

        en = 1'b0;
        do_load(8'h00, 8'h00, 8'h00, 1'b0);
        chk("rej00_err", load_err, 1);
        chk("rej00_time", now, 24'h010000);
        do_load(8'h13, 8'h00, 8'h00, 1'b0);
        chk("rej13_err", load_err, 1);
        chk("rej13_time", now, 24'h010000);
        en = 1'b1;
`else
        chk("rst_time", now, 24'h000000);
        rst = 1'b0;
        push(24'h000001, 1'b0, 1'b0);
        wait_pulse("first", 4);

        do_load(8'h00, 8'h00, 8'h59, 1'b0);
        chk("ld59_time", now, 24'h000059);
        chk("ld59_err", load_err, 0);
        push(24'h000100, 1'b0, 1'b0);
        wait_pulse("sec_carry", 4);

        do_load(8'h00, 8'h59, 8'h59, 1'b1);
        chk("ld5959_pm", pm, 0);
        push(24'h010000, 1'b0, 1'b0);
        wait_pulse("min_carry", 4);

        do_load(8'h23, 8'h59, 8'h59, 1'b0);
        push(24'h000000, 1'b0, 1'b1);
        wait_pulse("midnight", 4);

        en = 1'b0;
        do_load(8'h24, 8'h00, 8'h00, 1'b0);
        chk("rej24_err", load_err, 1);
        chk("rej24_time", now, 24'h000000);
        do_load(8'h12, 8'h60, 8'h00, 1'b0);
        chk("rej60_err", load_err, 1);
        chk("rej60_time", now, 24'h000000);
        do_load(8'h12, 8'h3A, 8'h00, 1'b0);
        chk("rej3A_err", load_err, 1);
        chk("rej3A_time", now, 24'h000000);
        @(negedge clk);
        chk("rej_err_off", load_err, 0);

        en = 1'b1;
        do_load(8'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        do_load(8'h10, 8'h20, 8'h30, 1'b0);
        chk("ldtick_time", now, 24'h102030);
        chk("ldtick_sec", sec_pulse, 0);
        push(24'h102031, 1'b0, 1'b0);
        wait_pulse("after_ldtick", 4);

        en = 1'b0;
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sec_pulse === 1'b1) pc++;
        end
        chk("hold_pulses", pc, 0);
        chk("hold_time", now, 24'h102031);
        en = 1'b1;
        push(24'h102032, 1'b0, 1'b0);
        wait_pulse("resume", 3);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_time", now, 24'h000000);
        chk("async_rst_sec", sec_pulse, 0);
        @(negedge clk);
        rst = 1'b0;
        push(24'h000001, 1'b0, 1'b0);
        wait_pulse("post_rst", 4);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_time_counter.md
# rtc_time_counter

Time-of-day core of the real-time digital clock. It divides the system clock to a 1 Hz tick and keeps hours, minutes and seconds as six packed BCD digits. The digits feed the per-digit BCD-to-seven-segment decoders directly. A host load port sets the time, and range-checks it first.

## Interface
- CLK_HZ, 50_000_000: system clock cycles per second; benches use small values, e.g. 4.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low freezes the prescaler and the time.
- load  in  1  single-cycle request to set the time from the load_* inputs.
- load_hh, load_mm, load_ss  in  8 each  BCD time to load, {tens, units}.
- load_pm  in  1  PM flag to load; used only when RTC_12H_EN is defined.
- hh_t, hh_u, mm_t, mm_u, ss_t, ss_u  out  4 each  current time digits; decoder-ready.
- pm  out  1  PM indicator; tied 0 without RTC_12H_EN.
- sec_pulse  out  1  one-cycle strobe whenever the seconds advance.
- day_pulse  out  1  one-cycle strobe on midnight rollover.
- load_err  out  1  one-cycle strobe when a load is rejected.

## Operation
- Prescaler `pre`, width clog2(CLK_HZ):
  - Counts 0..CLK_HZ-1 while en=1 and holds while en=0.
  - tick = en && pre==CLK_HZ-1; on tick, `pre` wraps to 0.
- On tick, time advances one second using a BCD ripple carry:
  - ss_u 9->0 carries into ss_t; ss_t 5->0 carries into mm_u.
  - mm_u 9->0 carries into mm_t; mm_t 5->0 carries into the hours.
- Hours, 24-hour mode: 23->00. The 23:59:59->00:00:00 step raises day_pulse.
- A digit never holds a value above 9. Tens digits never exceed their range: ss_t, mm_t ≤5; hh_t ≤2.
- Load:
  - Accepted if every nibble is ≤9, hh ≤23, mm ≤59 and ss ≤59.
  - On accept: all digits (and pm) are written, `pre` is cleared to 0, and no sec_pulse or day_pulse is raised.
  - On reject: no state changes and load_err strobes.
- Simultaneous load and tick: the load wins and the tick is discarded.
- A load is honoured even when en=0.

## Timing
- Reset values:
  - Without RTC_12H_EN: time 00:00:00, pm=0.
  - With RTC_12H_EN: time 12:00:00, pm=0.
  - Always: pre=0 and all strobes 0.
- Strobes are registered. sec_pulse and day_pulse are high in the cycle where the new digits first appear, i.e. the cycle after the edge on which tick was true.
- First sec_pulse after reset release with en=1 steady: CLK_HZ cycles after release. Thereafter exactly one every CLK_HZ cycles.
- Load latency: digits change at the clock edge sampling load=1. load_err is high the following cycle.
- After an accepted load, the next advance occurs CLK_HZ enabled cycles later.
- rst asserted mid-count clears all state immediately, independent of clk.

## Configuration
- RTC_12H_EN defined selects 12-hour mode:
  - Hours count 12,01,02..11.
  - 11:59:59->12:00:00 toggles pm.
  - day_pulse fires on the PM->AM transition only.
  - The load range for hours is 01..12, with load_pm applied.
- RTC_12H_EN undefined selects 24-hour mode as in Operation: load_pm is ignored and pm is constant 0.

## Structure
- Shared package rtc_pkg holds:
  - typedef bcd_t (4-bit) and typedef bcd2_t (8-bit tens/units).
  - Constants SEC_MAX=8'h59, MIN_MAX=8'h59, HR24_MAX=8'h23, HR12_MAX=8'h12, HR12_MIN=8'h01.
  - A function bcd2_valid(bcd2_t, bcd2_t max).
- One sub-module, rtc_bcd_mod60: two-digit BCD 00..59 counter with inc input and carry output.
  - Instantiated for seconds and minutes.
  - Hours logic is inline, because it differs per mode.

## Test plan
- Reset, CLK_HZ=4, en=1 -> 00:00:00 after reset; first sec_pulse 4 cycles after release; 00:00:01 shown the same cycle.
- Load 00:00:59 then wait one tick -> 00:01:00. Load 00:59:59 -> 01:00:00 with no day_pulse.
- Load 23:59:59 -> after one tick, 00:00:00 and day_pulse high for exactly one cycle.
- Load 24:00:00, then 12:60:00, then 12:3A:00 -> each raises load_err for one cycle, and the time is unchanged.
- Load asserted on the same cycle as tick with 10:20:30 -> digits read 10:20:30. The next sec_pulse comes 4 cycles later, and the skipped tick is not applied.
- en=0 for 20 cycles mid-second -> digits and pre hold. With RTC_12H_EN defined, loading 11:59:59 with pm=0 -> 12:00:00, pm=1 and no day_pulse.
